// File: rtl/aca_pkg.sv
// Shared constants and state encoding for the windowed almost-correct adder stage.
package aca_pkg;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_WINDOW = 6;
  localparam int ERR_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;
endpackage

// File: rtl/aca_error_detect.sv
// Flags any generate bit followed by WINDOW-1 propagate bits, i.e. a carry chain
// longer than one sub-adder window can see.
module aca_error_detect #(
  parameter int WIDTH  = aca_pkg::DEF_WIDTH,
  parameter int WINDOW = aca_pkg::DEF_WINDOW
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  output logic             err
);

  logic chain;

  always_comb begin
    err   = 1'b0;
    chain = 1'b0;
    for (int j = 0; j <= WIDTH - WINDOW; j++) begin
      chain = g[j];
      for (int m = 1; m < WINDOW; m++) begin
        chain = chain & p[j+m];
      end
      err = err | chain;
    end
  end

endmodule

// File: rtl/aca16_vl_adder.sv
// Variable-latency almost-correct adder: overlapping K-bit windows build the sum,
// long carry chains are flagged and optionally repaired with one extra cycle.
module aca16_vl_adder
  import aca_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int WINDOW  = DEF_WINDOW,
  parameter int RECOVER = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     input1_i,
  input  logic [WIDTH-1:0]     input2_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH-1:0]     sum_o,
  output logic                 carry_o,
  output logic                 err_o,
  output logic                 fixed_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [1:0]           state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid_o stays high with outputs frozen until ready_i completes the transfer.
  state_t               state;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [WIDTH-1:0]     g, p;
  logic [WIDTH-1:0]     approx_sum;
  logic                 approx_carry;
  logic [WIDTH:0]       exact_sum;
  logic                 err;
  logic [WIDTH-1:0]     win_top;
  logic [WINDOW-2:0]    approx_low;

  assign g = a_q & b_q;
  assign p = a_q ^ b_q;
  assign exact_sum = {1'b0, a_q} + {1'b0, b_q};

  // Window t covers bits t-WINDOW+1..t with zero carry-in; only its top sum bit is
  // kept, except the lowest window which supplies the exact low bits.
  genvar t;
  for (t = WINDOW - 1; t < WIDTH; t++) begin : g_win
    localparam int LO = t - WINDOW + 1;
    logic [WINDOW-1:0] c;

    always_comb begin
      c = '0;
      for (int m = 1; m < WINDOW; m++) begin
        c[m] = g[LO+m-1] | (p[LO+m-1] & c[m-1]);
      end
    end

    assign win_top[t] = p[t] ^ c[WINDOW-1];

    if (t == WINDOW - 1) begin : g_low
      assign approx_low = p[WINDOW-2:0] ^ c[WINDOW-2:0];
    end
    if (t == WIDTH - 1) begin : g_top
      assign approx_carry = g[WIDTH-1] | (p[WIDTH-1] & c[WINDOW-1]);
    end
  end

  assign approx_sum = {win_top[WIDTH-1:WINDOW-1], approx_low};

  aca_error_detect #(
    .WIDTH (WIDTH),
    .WINDOW(WINDOW)
  ) u_err (
    .g  (g),
    .p  (p),
    .err(err)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_o       <= '0;
      carry_o     <= 1'b0;
      err_o       <= 1'b0;
      fixed_o     <= 1'b0;
      err_count_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            a_q   <= input1_i;
            b_q   <= input2_i;
            state <= CALC;
          end
        end
        CALC: begin
          if (err && (err_count_o != {ERR_CNT_W{1'b1}})) begin
            err_count_o <= err_count_o + 1'b1;
          end
          if (err && (RECOVER != 0)) begin
            state <= FIX;
          end else begin
            sum_o   <= approx_sum;
            carry_o <= approx_carry;
            err_o   <= err;
            fixed_o <= 1'b0;
            state   <= OUT;
          end
        end
        FIX: begin
          sum_o   <= exact_sum[WIDTH-1:0];
          carry_o <= exact_sum[WIDTH];
          err_o   <= 1'b1;
          fixed_o <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (ready_i) begin
            if (valid_i) begin
              a_q   <= input1_i;
              b_q   <= input2_i;
              state <= CALC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign valid_o = (state == OUT);
  assign ready_o = (state == IDLE) | ((state == OUT) & ready_i);
  assign state_o = state;

endmodule
